// File: rtl/traffic_phase_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_phase_ctrl
//  Purpose  : N-approach traffic-light phase sequencer. Green, yellow and
//             all-red run round-robin across the approaches. Latched
//             pedestrian requests are served in a WALK phase, and night mode
//             flashes all yellow lamps.
//  Revision : 1.0  initial release
// ============================================================================
module traffic_phase_ctrl #(
  parameter int N_APPROACH   = 2,
  parameter int TICK_DIV     = 1000,
  parameter int CNT_W        = 16,
  parameter int GREEN_TICKS  = 20,
  parameter int YELLOW_TICKS = 4,
  parameter int ALLRED_TICKS = 2,
  parameter int WALK_TICKS   = 10,
  parameter int FLASH_TICKS  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_APPROACH-1:0] ped_req,
  input  logic                  night_mode,
  output logic [N_APPROACH-1:0] red,
  output logic [N_APPROACH-1:0] yellow,
  output logic [N_APPROACH-1:0] green,
  output logic [N_APPROACH-1:0] walk,
  output logic [1:0]            phase,
  output logic [2:0]            state
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [2:0] S_ALLRED = 3'd0;
  localparam logic [2:0] S_GREEN  = 3'd1;
  localparam logic [2:0] S_YELLOW = 3'd2;
  localparam logic [2:0] S_WALK   = 3'd3;
  localparam logic [2:0] S_FLASH  = 3'd4;

  // Prescaler only needs to reach TICK_DIV-1.
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  // Timer reload values: a state of D ticks counts D-1 down to 0.
  localparam logic [CNT_W-1:0] GREEN_LOAD  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] YELLOW_LOAD = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] ALLRED_LOAD = CNT_W'(ALLRED_TICKS - 1);
  localparam logic [CNT_W-1:0] WALK_LOAD   = CNT_W'(WALK_TICKS - 1);
  localparam logic [CNT_W-1:0] FLASH_LOAD  = CNT_W'(FLASH_TICKS - 1);

  localparam logic [N_APPROACH-1:0] ALL_ON  = '1;
  localparam logic [N_APPROACH-1:0] ALL_OFF = '0;
  localparam logic [1:0] LAST_PHASE = 2'(N_APPROACH - 1);

  localparam longint MAX_TIMER = longint'(1) << CNT_W;

  // --------------------------------------------------------------------------
  // Elaboration-time configuration checks
  // --------------------------------------------------------------------------
  if (N_APPROACH < 2 || N_APPROACH > 4) begin : g_bad_approach
    $error("traffic_phase_ctrl: N_APPROACH must be in 2..4");
  end

  if (TICK_DIV < 1) begin : g_bad_tick_div
    $error("traffic_phase_ctrl: TICK_DIV must be >= 1");
  end

  if (GREEN_TICKS < 1 || YELLOW_TICKS < 1 || ALLRED_TICKS < 1 ||
      WALK_TICKS < 1 || FLASH_TICKS < 1) begin : g_bad_duration
    $error("traffic_phase_ctrl: every duration must be >= 1 tick");
  end

  if (longint'(GREEN_TICKS)  > MAX_TIMER || longint'(YELLOW_TICKS) > MAX_TIMER ||
      longint'(ALLRED_TICKS) > MAX_TIMER || longint'(WALK_TICKS)   > MAX_TIMER ||
      longint'(FLASH_TICKS)  > MAX_TIMER) begin : g_bad_cnt_w
    $error("traffic_phase_ctrl: a duration does not fit in CNT_W bits");
  end

  // --------------------------------------------------------------------------
  // Internal state
  // --------------------------------------------------------------------------
  logic [PRE_W-1:0]      prescaler;
  logic [CNT_W-1:0]      timer;
  logic [N_APPROACH-1:0] pending;

  logic                  tick;
  logic                  expire;

  logic [2:0]            state_nxt;
  logic [1:0]            phase_nxt;
  logic [PRE_W-1:0]      prescaler_nxt;
  logic [CNT_W-1:0]      timer_nxt;
  logic [N_APPROACH-1:0] pending_nxt;
  logic [CNT_W-1:0]      load_val;

  logic [N_APPROACH-1:0] red_nxt;
  logic [N_APPROACH-1:0] yellow_nxt;
  logic [N_APPROACH-1:0] green_nxt;
  logic [N_APPROACH-1:0] walk_nxt;
  logic [N_APPROACH-1:0] phase_onehot;

  // A tick is the last clock of a prescaler period; a state (or a flash
  // half-period) ends on the tick where the timer has already reached 0.
  assign tick   = (prescaler == PRE_LAST);
  assign expire = tick && (timer == '0);

  // Register every state element and every lamp output on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_ALLRED;
      phase     <= 2'd0;
      red       <= ALL_ON;
      yellow    <= ALL_OFF;
      green     <= ALL_OFF;
      walk      <= ALL_OFF;
      pending   <= ALL_OFF;
      prescaler <= '0;
      // Reset enters ALLRED, so the timer holds the ALLRED reload value
      // (0 for a one-tick all-red) and the first all-red lasts its full time.
      timer     <= ALLRED_LOAD;
    end else begin
      state     <= state_nxt;
      phase     <= phase_nxt;
      red       <= red_nxt;
      yellow    <= yellow_nxt;
      green     <= green_nxt;
      walk      <= walk_nxt;
      pending   <= pending_nxt;
      prescaler <= prescaler_nxt;
      timer     <= timer_nxt;
    end
  end

  // Next-state, next-phase, timing and pending-request logic.
  always_comb begin
    state_nxt = state;
    phase_nxt = phase;

    if (expire) begin
      case (state)
        S_ALLRED: begin
          // Night mode outranks pedestrians; both are only honoured here.
          if (night_mode) begin
            state_nxt = S_FLASH;
          end else if (pending != ALL_OFF) begin
            state_nxt = S_WALK;
          end else begin
            state_nxt = S_GREEN;
          end
        end
        S_GREEN: begin
          state_nxt = S_YELLOW;
        end
        S_YELLOW: begin
          state_nxt = S_ALLRED;
          phase_nxt = (phase == LAST_PHASE) ? 2'd0 : (phase + 2'd1);
        end
        S_WALK: begin
          state_nxt = S_GREEN;
        end
        S_FLASH: begin
          // While night mode holds, the boundary is just a lamp toggle.
          if (!night_mode) begin
            state_nxt = S_ALLRED;
            phase_nxt = 2'd0;
          end
        end
        default: begin
          state_nxt = S_ALLRED;
          phase_nxt = 2'd0;
        end
      endcase
    end

    case (state_nxt)
      S_GREEN:  load_val = GREEN_LOAD;
      S_YELLOW: load_val = YELLOW_LOAD;
      S_WALK:   load_val = WALK_LOAD;
      S_FLASH:  load_val = FLASH_LOAD;
      default:  load_val = ALLRED_LOAD;
    endcase

    // Clearing the prescaler on every boundary keeps each state exactly
    // D*TICK_DIV clocks long regardless of where the previous one ended.
    if (expire) begin
      prescaler_nxt = '0;
      timer_nxt     = load_val;
    end else if (tick) begin
      prescaler_nxt = '0;
      timer_nxt     = timer - CNT_W'(1);
    end else begin
      prescaler_nxt = prescaler + PRE_W'(1);
      timer_nxt     = timer;
    end

    // Requests are dropped in flash operation. On WALK entry the pending set
    // moves to the walk lamps, and a request seen on that same edge starts
    // the next pending set so it is not lost.
    if (state == S_FLASH || state_nxt == S_FLASH) begin
      pending_nxt = ALL_OFF;
    end else if (state == S_ALLRED && state_nxt == S_WALK) begin
      pending_nxt = ped_req;
    end else begin
      pending_nxt = pending | ped_req;
    end
  end

  // Lamp values for the state being entered (or held) on the next edge.
  always_comb begin
    phase_onehot = N_APPROACH'(1) << phase_nxt;
    red_nxt      = ALL_ON;
    yellow_nxt   = ALL_OFF;
    green_nxt    = ALL_OFF;
    walk_nxt     = ALL_OFF;

    case (state_nxt)
      S_GREEN: begin
        green_nxt = phase_onehot;
        red_nxt   = ~phase_onehot;
      end
      S_YELLOW: begin
        yellow_nxt = phase_onehot;
        red_nxt    = ~phase_onehot;
      end
      S_WALK: begin
        // Walk lamps are captured from pending on entry and then held.
        walk_nxt = (state == S_WALK) ? walk : pending;
      end
      S_FLASH: begin
        red_nxt = ALL_OFF;
        if (state != S_FLASH) begin
          yellow_nxt = ALL_ON;
        end else if (expire) begin
          yellow_nxt = ~yellow;
        end else begin
          yellow_nxt = yellow;
        end
      end
      default: begin
        red_nxt = ALL_ON;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_traffic_phase_ctrl
//  Purpose  : Self-checking bench for traffic_phase_ctrl. Two instances
//             (TICK_DIV=1 and TICK_DIV=3) share the inputs; a clock-level
//             behavioural model per instance is compared every cycle, and
//             directed scenarios add literal expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_traffic_phase_ctrl;

  localparam int N  = 2;
  localparam int GT = 4;
  localparam int YT = 2;
  localparam int AT = 1;
  localparam int WT = 3;
  localparam int FT = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] ped_req = '0;
  logic         night_mode = 1'b0;

  logic [N-1:0] red0, yellow0, green0, walk0;
  logic [1:0]   phase0;
  logic [2:0]   state0;
  logic [N-1:0] red1, yellow1, green1, walk1;
  logic [1:0]   phase1;
  logic [2:0]   state1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  traffic_phase_ctrl #(
    .N_APPROACH(N), .TICK_DIV(1), .CNT_W(8), .GREEN_TICKS(GT),
    .YELLOW_TICKS(YT), .ALLRED_TICKS(AT), .WALK_TICKS(WT), .FLASH_TICKS(FT)
  ) dut (
    .clk(clk), .rst(rst), .ped_req(ped_req), .night_mode(night_mode),
    .red(red0), .yellow(yellow0), .green(green0), .walk(walk0),
    .phase(phase0), .state(state0)
  );

  traffic_phase_ctrl #(
    .N_APPROACH(N), .TICK_DIV(3), .CNT_W(8), .GREEN_TICKS(GT),
    .YELLOW_TICKS(YT), .ALLRED_TICKS(AT), .WALK_TICKS(WT), .FLASH_TICKS(FT)
  ) dut3 (
    .clk(clk), .rst(rst), .ped_req(ped_req), .night_mode(night_mode),
    .red(red1), .yellow(yellow1), .green(green1), .walk(walk1),
    .phase(phase1), .state(state1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------------
  // Behavioural model: state name, approach and clocks left in the state.
  // 0=ALLRED 1=GREEN 2=YELLOW 3=WALK 4=FLASH
  // ------------------------------------------------------------------------
  int           m_state [2];
  int           m_phase [2];
  int           m_left  [2];
  logic [N-1:0] m_pend  [2];
  logic [N-1:0] m_walk  [2];
  logic [N-1:0] m_yel   [2];
  bit           m_valid = 1'b0;

  function automatic int dur(input int s);
    case (s)
      1:       return GT;
      2:       return YT;
      3:       return WT;
      4:       return FT;
      default: return AT;
    endcase
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int  div;
      int  ns;
      int  np;
      bit  done;
      div = (k == 0) ? 1 : 3;
      if (rst) begin
        m_state[k] = 0;
        m_phase[k] = 0;
        m_left[k]  = AT * div;
        m_pend[k]  = '0;
        m_walk[k]  = '0;
        m_yel[k]   = '0;
      end else begin
        ns   = m_state[k];
        np   = m_phase[k];
        m_left[k] = m_left[k] - 1;
        done = (m_left[k] == 0);
        if (done) begin
          case (m_state[k])
            0:       ns = night_mode ? 4 : ((m_pend[k] != 0) ? 3 : 1);
            1:       ns = 2;
            2:       begin ns = 0; np = (np + 1) % N; end
            3:       ns = 1;
            default: if (!night_mode) begin ns = 0; np = 0; end
          endcase
          m_left[k] = dur(ns) * div;
        end
        if (m_state[k] == 4 || ns == 4) begin
          m_pend[k] = '0;
        end else if (m_state[k] == 0 && ns == 3) begin
          m_walk[k] = m_pend[k];
          m_pend[k] = ped_req;
        end else begin
          m_pend[k] = m_pend[k] | ped_req;
        end
        if (ns == 4) begin
          if (m_state[k] != 4) m_yel[k] = '1;
          else if (done)       m_yel[k] = ~m_yel[k];
        end
        m_state[k] = ns;
        m_phase[k] = np;
      end
    end
    if (rst) m_valid = 1'b1;
  end

  // Compare both instances against the model, away from the active edge.
  always @(negedge clk) begin
    logic [N-1:0] er, ey, eg, ew, oh;
    logic [N-1:0] ar, ay, ag, aw;
    logic [1:0]   ap;
    logic [2:0]   as;
    if (m_valid) begin
      for (int k = 0; k < 2; k++) begin
        oh = N'(1) << m_phase[k];
        er = '1; ey = '0; eg = '0; ew = '0;
        case (m_state[k])
          1:       begin eg = oh; er = ~oh; end
          2:       begin ey = oh; er = ~oh; end
          3:       ew = m_walk[k];
          4:       begin er = '0; ey = m_yel[k]; end
          default: ;
        endcase
        ar = (k == 0) ? red0    : red1;
        ay = (k == 0) ? yellow0 : yellow1;
        ag = (k == 0) ? green0  : green1;
        aw = (k == 0) ? walk0   : walk1;
        ap = (k == 0) ? phase0  : phase1;
        as = (k == 0) ? state0  : state1;
        chk($sformatf("model%0d_red", k),    32'(ar), 32'(er));
        chk($sformatf("model%0d_yellow", k), 32'(ay), 32'(ey));
        chk($sformatf("model%0d_green", k),  32'(ag), 32'(eg));
        chk($sformatf("model%0d_walk", k),   32'(aw), 32'(ew));
        chk($sformatf("model%0d_phase", k),  32'(ap), 32'(m_phase[k]));
        chk($sformatf("model%0d_state", k),  32'(as), 32'(m_state[k]));
      end
    end
  end

  // ------------------------------------------------------------------------
  // Directed scenarios: point c is the negedge before edge c; inputs set at
  // point c are sampled by edge c.
  // ------------------------------------------------------------------------
  task automatic run_scn(input int id, input int len);
    rst = 1'b1; ped_req = '0; night_mode = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < len; c++) begin
      case (id)
        1: begin
          if (c == 0)  begin chk("idle_c0_state", 32'(state0), 0); chk("idle_c0_red", 32'(red0), 32'h3); end
          if (c == 1)  chk("idle_c1_green", 32'(green0), 32'h1);
          if (c == 4)  chk("idle_c4_green", 32'(green0), 32'h1);
          if (c == 5)  chk("idle_c5_yellow", 32'(yellow0), 32'h1);
          if (c == 6)  chk("idle_c6_yellow", 32'(yellow0), 32'h1);
          if (c == 7)  chk("idle_c7_state", 32'(state0), 0);
          if (c == 8)  begin chk("idle_c8_green", 32'(green0), 32'h2); chk("idle_c8_phase", 32'(phase0), 1); end
          if (c == 13) chk("idle_c13_yellow", 32'(yellow0), 32'h2);
          if (c == 14) begin chk("idle_c14_state", 32'(state0), 0); chk("idle_c14_phase", 32'(phase0), 0); end
          if (c == 15) chk("idle_c15_green", 32'(green0), 32'h1);
          if (c == 2)  chk("div3_c2_state", 32'(state1), 0);
          if (c == 3)  chk("div3_c3_green", 32'(green1), 32'h1);
          if (c == 14) chk("div3_c14_green", 32'(green1), 32'h1);
          if (c == 15) chk("div3_c15_yellow", 32'(yellow1), 32'h1);
        end
        2: begin
          ped_req = (c == 2) ? 2'b10 : 2'b00;
          if (c == 8)  begin chk("ped1_c8_walk", 32'(walk0), 32'h2); chk("ped1_c8_state", 32'(state0), 3); end
          if (c == 8)  chk("ped1_c8_model_state", 32'(m_state[0]), 3);
          if (c == 10) chk("ped1_c10_walk", 32'(walk0), 32'h2);
          if (c == 11) begin chk("ped1_c11_green", 32'(green0), 32'h2); chk("ped1_c11_walk", 32'(walk0), 0); end
          if (c == 14) chk("ped1_c14_green", 32'(green0), 32'h2);
          if (c == 18) chk("ped1_c18_state", 32'(state0), 1);
        end
        3: begin
          ped_req = (c >= 2 && c <= 9) ? 2'b11 : 2'b00;
          if (c == 8)  chk("ped11_c8_walk", 32'(walk0), 32'h3);
          if (c == 17) chk("ped11_c17_state", 32'(state0), 0);
          if (c == 18) begin chk("ped11_c18_state", 32'(state0), 3); chk("ped11_c18_walk", 32'(walk0), 32'h3); end
          if (c == 20) chk("ped11_c20_walk", 32'(walk0), 32'h3);
          if (c == 21) chk("ped11_c21_green", 32'(green0), 32'h1);
        end
        4: begin
          night_mode = (c >= 3 && c < 11);
          if (c == 5)  chk("night_c5_yellow", 32'(yellow0), 32'h1);
          if (c == 8)  begin chk("night_c8_state", 32'(state0), 4); chk("night_c8_yellow", 32'(yellow0), 32'h3); chk("night_c8_red", 32'(red0), 0); end
          if (c == 8)  chk("night_c8_model_yel", 32'(m_yel[0]), 32'h3);
          if (c == 9)  chk("night_c9_yellow", 32'(yellow0), 32'h3);
          if (c == 10) chk("night_c10_yellow", 32'(yellow0), 0);
          if (c == 11) chk("night_c11_yellow", 32'(yellow0), 0);
          if (c == 12) begin chk("night_c12_state", 32'(state0), 0); chk("night_c12_red", 32'(red0), 32'h3); end
          if (c == 13) chk("night_c13_green", 32'(green0), 32'h1);
        end
        default: begin
          rst = (c == 9);
          if (c == 9)  chk("rst_c9_green", 32'(green0), 32'h2);
          if (c == 10) begin
            chk("rst_c10_red", 32'(red0), 32'h3);
            chk("rst_c10_state", 32'(state0), 0);
            chk("rst_c10_phase", 32'(phase0), 0);
            chk("rst_c10_green", 32'(green0), 0);
          end
        end
      endcase
      @(negedge clk);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    run_scn(1, 16);
    run_scn(2, 22);
    run_scn(3, 22);
    run_scn(4, 14);
    run_scn(5, 11);

    // Randomized traffic: sparse pedestrian pulses, long night-mode
    // stretches and occasional resets, checked by the model every cycle.
    rst = 1'b0; ped_req = '0; night_mode = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      ped_req = ($urandom_range(0, 9) == 0) ? N'($urandom) : '0;
      if ($urandom_range(0, 79) == 0) night_mode = ~night_mode;
      rst = ($urandom_range(0, 499) == 0);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
